// File: rtl/ps2_emit_if.sv
// Signal bundle between the button sources and the two-controller code-bus emitter.
// The host side (buttons, enable) is the master; the emitter is the slave.
interface ps2_emit_if;
  logic       enable;
  logic [9:0] c1;
  logic [9:0] c2;
  logic [4:0] GPIO_0;
  logic       busy;
  logic       frame_done;

  modport master (
    output enable, c1, c2,
    input  GPIO_0, busy, frame_done
  );

  modport slave (
    input  enable, c1, c2,
    output GPIO_0, busy, frame_done
  );
endinterface

// File: rtl/ps2_emit.sv
// Serialises pressed buttons of two controllers round-robin onto the 5-wire code bus.
// Define PS2_EMIT_PRESEL_EN to add a one-cycle SETUP state that settles select before the code.
module ps2_emit #(
  parameter int unsigned HOLD_CYCLES = 500100,
  parameter int unsigned GAP_CYCLES  = 1000
) (
  input logic       clock,
  input logic       reset,
  ps2_emit_if.slave bus
);

  localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [4:0] LastSlot  = 5'd19;
  localparam logic [4:0] MissLimit = 5'd19;

  typedef enum logic [2:0] {StIdle, StScan, StSetup, StDrive, StGap} state_e;

  state_e          state_q, state_d;
  logic [4:0]      ptr_q, ptr_d;
  logic [4:0]      miss_q, miss_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_q, sel_d;
  logic [3:0]      code_q, code_d;
  logic [4:0]      gpio_q, gpio_d;
  logic            done_q, done_d;
  logic [19:0]     slots;
  logic            hit;

  assign slots = {bus.c2, bus.c1};
  assign hit   = slots[ptr_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      miss_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      code_q  <= '0;
      gpio_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      gpio_q  <= gpio_d;
      done_q  <= done_d;
    end
  end

  // Hold/gap counter is zero on every state entry; it only counts while DRIVE or GAP persists.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    miss_d  = miss_q;
    cnt_d   = '0;
    sel_d   = sel_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (bus.enable && (|slots)) begin
          state_d = StScan;
          miss_d  = '0;
        end
      end
      StScan: begin
        ptr_d = (ptr_q == LastSlot) ? 5'd0 : ptr_q + 5'd1;
        if (!bus.enable) begin
          state_d = StIdle;
        end else if (hit) begin
          sel_d  = (ptr_q >= 5'd10);
          code_d = sel_d ? 4'(ptr_q - 5'd9) : 4'(ptr_q + 5'd1);
`ifdef PS2_EMIT_PRESEL_EN
          state_d = StSetup;
`else
          state_d = StDrive;
`endif
        end else if (miss_q == MissLimit) begin
          state_d = StIdle;
        end else begin
          miss_d = miss_q + 5'd1;
        end
      end
      StSetup: state_d = StDrive;
      StDrive: begin
        if (cnt_q == HoldLast) state_d = StGap;
        else                   cnt_d   = cnt_q + CntW'(1);
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = bus.enable ? StScan : StIdle;
          miss_d  = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus value is registered from the current state, so it trails the state by one cycle.
  always_comb begin
    gpio_d   = '0;
    done_d   = 1'b0;
    bus.busy = (state_q != StIdle);
    unique case (state_q)
      StSetup: gpio_d = {sel_q, 4'b0000};
      StDrive: gpio_d = {sel_q, code_q};
      StGap:   done_d = (cnt_q == GapLast);
      default: ;
    endcase
  end

  assign bus.GPIO_0     = gpio_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_ps2_emit.sv
// Bench for ps2_emit: frame-level round-robin model predicts each code, its lead-in,
// hold length, gap and frame_done pulse; randomized button patterns exercise fairness.
module tb_ps2_emit;

  localparam int Hold = 8;
  localparam int Gap  = 2;
`ifdef PS2_EMIT_PRESEL_EN
  localparam int Setup = 1;
`else
  localparam int Setup = 0;
`endif

  logic clock;
  logic reset;
  int   checks;
  int   passed;
  int   m_ptr;

  ps2_emit_if bus ();

  ps2_emit #(
    .HOLD_CYCLES(Hold),
    .GAP_CYCLES (Gap)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] slot_bus(input int s);
    logic [3:0] c;
    if (s < 10) begin
      c = 4'(s + 1);
      return {1'b0, c};
    end
    c = 4'(s - 9);
    return {1'b1, c};
  endfunction

  // Called with the DUT in SCAN (just after the request edge or the last gap edge).
  task automatic check_frame(input string name, input int mid, input logic [9:0] mc1,
                             input logic [9:0] mc2, input logic men);
    logic [19:0] btn;
    logic [4:0]  exp;
    int          s;
    int          m;
    btn = {bus.c2, bus.c1};
    s = -1;
    m = 0;
    for (int i = 0; i < 20; i++) begin
      if (s < 0 && btn[(m_ptr + i) % 20]) begin
        s = (m_ptr + i) % 20;
        m = i;
      end
    end
    checks++;
    if (s < 0) begin
      $display("FAIL %s: no pressed button to send", name);
      return;
    end
    passed++;
    exp   = slot_bus(s);
    m_ptr = (s + 1) % 20;
    for (int i = 0; i <= m; i++) begin
      tick();
      checks++;
      if (bus.GPIO_0 !== 5'b0 || bus.busy !== 1'b1)
        $display("FAIL %s lead %0d: gpio=%b busy=%b want 00000/1", name, i, bus.GPIO_0, bus.busy);
      else passed++;
    end
    if (Setup != 0) begin
      tick();
      checks++;
      if (bus.GPIO_0 !== {exp[4], 4'b0000})
        $display("FAIL %s setup: gpio=%b want %b", name, bus.GPIO_0, {exp[4], 4'b0000});
      else passed++;
    end
    for (int i = 0; i < Hold; i++) begin
      tick();
      if (i == mid) begin
        bus.c1     = mc1;
        bus.c2     = mc2;
        bus.enable = men;
      end
      checks++;
      if (bus.GPIO_0 !== exp || bus.busy !== 1'b1 || bus.frame_done !== 1'b0)
        $display("FAIL %s hold %0d: gpio=%b busy=%b done=%b want %b/1/0", name, i,
                 bus.GPIO_0, bus.busy, bus.frame_done, exp);
      else passed++;
    end
    for (int i = 0; i < Gap; i++) begin
      tick();
      checks++;
      if (bus.GPIO_0 !== 5'b0 || bus.frame_done !== (i == Gap - 1))
        $display("FAIL %s gap %0d: gpio=%b done=%b want 00000/%0d", name, i,
                 bus.GPIO_0, bus.frame_done, (i == Gap - 1));
      else passed++;
    end
  endtask

  task automatic check_idle_out(input string name);
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (bus.GPIO_0 !== 5'b0 || bus.busy !== (i < 20))
        $display("FAIL %s scan %0d: gpio=%b busy=%b want 00000/%0d", name, i,
                 bus.GPIO_0, bus.busy, (i < 20));
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    bus.enable = 1'b0;
    bus.c1     = '0;
    bus.c2     = '0;
    tick();
    tick();
    checks++;
    if (bus.GPIO_0 !== 5'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0)
      $display("FAIL reset: gpio=%b busy=%b done=%b want 00000/0/0",
               bus.GPIO_0, bus.busy, bus.frame_done);
    else passed++;
    reset = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_reset_mid_drive();
    bus.c1     = 10'b0000000001;
    bus.enable = 1'b1;
    for (int i = 0; i < 4 + Setup; i++) tick();
    checks++;
    if (bus.GPIO_0 !== 5'b00001) $display("FAIL pre_reset: gpio=%b want 00001", bus.GPIO_0);
    else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.GPIO_0 !== 5'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0)
      $display("FAIL async_reset: gpio=%b busy=%b done=%b want 00000/0/0",
               bus.GPIO_0, bus.busy, bus.frame_done);
    else passed++;
    tick();
    checks++;
    if (bus.GPIO_0 !== 5'b0 || bus.busy !== 1'b0)
      $display("FAIL held_reset: gpio=%b busy=%b want 00000/0", bus.GPIO_0, bus.busy);
    else passed++;
    reset = 1'b1;
    m_ptr = 0;
    tick();
    check_frame("start_c1", -1, '0, '0, 1'b1);
  endtask

  task automatic test_start_c2();
    bus.c1 = '0;
    bus.c2 = 10'b1000000000;
    checks++;
    if (slot_bus((m_ptr + 18) % 20) !== 5'b11010)
      $display("FAIL start_c2_slot: ptr=%0d want 1", m_ptr);
    else passed++;
    check_frame("start_c2", -1, '0, '0, 1'b1);
  endtask

  task automatic test_alternate();
    bus.c1 = 10'b0000100000;
    bus.c2 = 10'b0000000010;
    for (int f = 0; f < 4; f++) check_frame($sformatf("alternate%0d", f), -1, '0, '0, 1'b1);
  endtask

  task automatic test_release();
    bus.c1 = 10'b0001000000;
    bus.c2 = '0;
    check_frame("release", 2, '0, '0, 1'b1);
    check_idle_out("release_idle");
  endtask

  task automatic test_enable_drop();
    bus.c1     = 10'b0011110000;
    bus.c2     = 10'b0000000100;
    bus.enable = 1'b1;
    tick();
    check_frame("en_drop", 1, bus.c1, bus.c2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.GPIO_0 !== 5'b0 || bus.busy !== 1'b0)
        $display("FAIL en_off %0d: gpio=%b busy=%b want 00000/0", i, bus.GPIO_0, bus.busy);
      else passed++;
      tick();
    end
    bus.enable = 1'b1;
    tick();
    check_frame("en_resume", -1, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      bus.c1 = 10'($urandom) & 10'($urandom) & 10'($urandom);
      bus.c2 = 10'($urandom) & 10'($urandom) & 10'($urandom);
      if ({bus.c2, bus.c1} == 20'b0) bus.c2 = 10'(1 << $urandom_range(9, 0));
      for (int f = 0; f < 4; f++) check_frame($sformatf("rand%0d_%0d", r, f), -1, '0, '0, 1'b1);
    end
    bus.c1 = '0;
    bus.c2 = '0;
    check_idle_out("final_idle");
  endtask

  initial begin
    checks = 0;
    passed = 0;
    m_ptr  = 0;
    test_reset();
    test_reset_mid_drive();
    test_start_c2();
    test_alternate();
    test_release();
    test_enable_drop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
